vga_mode_scheduler: RTL and testbench

Display-mode controller in front of the VGA channel combiner. Turns the raw "negative display" and "imba mode" push-buttons into the registered `NEG_DIS` and `IMBA_MODE_ON` select lines. Mode changes are deferred to a frame boundary so the combiner never switches mid-frame. An optional forced-blank interval hides each transition.

---
 rtl/vga_mode_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_mode_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_scheduler.sv
// ----------------------------------------------------------------------------
// vga_mode_scheduler
//
// Display-mode controller in front of the VGA channel combiner. Two raw
// push-buttons are synchronised and debounced. Each accepted press toggles a
// shadow target. The targets are copied into the NEG_DIS / IMBA_MODE_ON select
// lines only at a frame boundary, so the combiner never switches mid-frame.
//
// Optional feature macro: VGA_MODE_BLANK_EN
//   defined   : each applied change forces BLANK high for BLANK_FRAMES frames,
//               starting at the applying frame (BLANKING state + frame counter).
//   undefined : BLANK is tied low; the FSM returns to IDLE right after applying.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a level (>=2)
//   BLANK_FRAMES    : frames of forced blank per mode change (>=1)
//
// Ports
//   CLK          in  : pixel/system clock, rising edge
//   RESET_N      in  : asynchronous active-low reset
//   BTN_NEG      in  : raw button, each press toggles negative display
//   BTN_IMBA     in  : raw button, each press toggles imba mode
//   FRAME_START  in  : one-cycle pulse at start of vertical blanking
//   NEG_DIS      out : active negative-display select (registered)
//   IMBA_MODE_ON out : active imba-mode select (registered)
//   BLANK        out : forces downstream pixels black (registered)
//   MODE_BUSY    out : high while the FSM is not IDLE (registered)
// ----------------------------------------------------------------------------
module vga_mode_scheduler #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int BLANK_FRAMES    = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic BTN_NEG,
    input  logic BTN_IMBA,
    input  logic FRAME_START,
    output logic NEG_DIS,
    output logic IMBA_MODE_ON,
    output logic BLANK,
    output logic MODE_BUSY
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the last differing cycle before the level is accepted.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef VGA_MODE_BLANK_EN
    localparam int FRM_W = $clog2(BLANK_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_LOAD = FRM_W'(BLANK_FRAMES);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_BLANKING   = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE       = 1'b0,
        S_WAIT_FRAME = 1'b1
    } state_t;
`endif

    // Bit 0 = negative display, bit 1 = imba mode throughout.
    logic [1:0]       w_btn;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_d;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_press;
    logic [1:0]       r_tgt;
    logic [1:0]       r_act;
    logic             r_busy;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       w_act_nxt;

`ifdef VGA_MODE_BLANK_EN
    logic             r_blank;
    logic             w_blank_nxt;
    logic [FRM_W-1:0] r_frm;
    logic [FRM_W-1:0] w_frm_nxt;
`else
    logic             w_unused_cfg;
    assign w_unused_cfg = (BLANK_FRAMES < 32'sd1);
`endif

    assign w_btn = {BTN_IMBA, BTN_NEG};

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive cycles the synchronised level disagrees with
    // the accepted level; accept it once the run is DEBOUNCE_CYCLES long.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_deb   <= 2'b00;
            r_deb_d <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= {CNT_W{1'b0}};
            end
        end else begin
            r_deb_d <= r_deb;
            for (int b = 0; b < 2; b++) begin
                if (r_sync2[b] == r_deb[b]) begin
                    r_cnt[b] <= {CNT_W{1'b0}};
                end else if (r_cnt[b] == DEB_LAST) begin
                    r_deb[b] <= r_sync2[b];
                    r_cnt[b] <= {CNT_W{1'b0}};
                end else begin
                    r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // A press is a rising edge of the debounced level.
    assign w_press = r_deb & ~r_deb_d;

    // Shadow targets toggle per press; a second press cancels a pending change.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tgt <= 2'b00;
        end else begin
            r_tgt <= r_tgt ^ w_press;
        end
    end

    // Next-state and next-output logic of the mode FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_act_nxt   = r_act;
`ifdef VGA_MODE_BLANK_EN
        w_blank_nxt = r_blank;
        w_frm_nxt   = r_frm;
`endif
        case (r_state)
            S_IDLE: begin
                // A FRAME_START here is deliberately ignored; application
                // needs a frame boundary seen while already waiting.
                if (r_tgt != r_act) begin
                    w_state_nxt = S_WAIT_FRAME;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_FRAME: begin
                if (r_tgt == r_act) begin
                    w_state_nxt = S_IDLE;
                end else if (FRAME_START) begin
                    w_act_nxt = r_tgt;
`ifdef VGA_MODE_BLANK_EN
                    w_blank_nxt = 1'b1;
                    w_frm_nxt   = FRM_LOAD;
                    w_state_nxt = S_BLANKING;
`else
                    w_state_nxt = S_IDLE;
`endif
                end else begin
                    w_state_nxt = S_WAIT_FRAME;
                end
            end
`ifdef VGA_MODE_BLANK_EN
            S_BLANKING: begin
                // Presses here only move the targets; they are serviced
                // after returning to IDLE with a fresh blank interval.
                if (FRAME_START) begin
                    if (r_frm == FRM_ONE) begin
                        w_blank_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frm_nxt = r_frm - FRM_ONE;
                    end
                end else begin
                    w_state_nxt = S_BLANKING;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
`ifdef VGA_MODE_BLANK_EN
                w_blank_nxt = 1'b0;
`endif
            end
        endcase
    end

    // FSM state and registered outputs; MODE_BUSY follows the next state so it
    // changes in the same cycle as the state itself.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_act   <= 2'b00;
            r_busy  <= 1'b0;
`ifdef VGA_MODE_BLANK_EN
            r_blank <= 1'b0;
            r_frm   <= {FRM_W{1'b0}};
`endif
        end else begin
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
`ifdef VGA_MODE_BLANK_EN
            r_blank <= w_blank_nxt;
            r_frm   <= w_frm_nxt;
`endif
        end
    end

    assign NEG_DIS      = r_act[0];
    assign IMBA_MODE_ON = r_act[1];
    assign MODE_BUSY    = r_busy;
`ifdef VGA_MODE_BLANK_EN
    assign BLANK        = r_blank;
`else
    assign BLANK        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mode_scheduler.sv
module tb_vga_mode_scheduler;

    localparam int DEB = 4;
    localparam int BF  = 2;
    localparam int FP  = 1000;
`ifdef VGA_MODE_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic BTN_NEG = 1'b0;
    logic BTN_IMBA = 1'b0;
    logic FRAME_START = 1'b0;
    logic NEG_DIS, IMBA_MODE_ON, BLANK, MODE_BUSY;

    int total = 0;
    int bad = 0;
    int fc = 0;

    vga_mode_scheduler #(.DEBOUNCE_CYCLES(DEB), .BLANK_FRAMES(BF)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BTN_NEG(BTN_NEG), .BTN_IMBA(BTN_IMBA),
        .FRAME_START(FRAME_START), .NEG_DIS(NEG_DIS), .IMBA_MODE_ON(IMBA_MODE_ON),
        .BLANK(BLANK), .MODE_BUSY(MODE_BUSY)
    );

    always #5 CLK = ~CLK;

    // Frame timing: one-cycle FRAME_START every FP cycles, changed away from the edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            fc++;
            FRAME_START = ((fc % FP) == 0);
        end
    end

    // ---------------- reference model ----------------
    // Debounce rule: the accepted level flips once the last DEB synchronised
    // samples (raw samples 2..DEB+1 edges old) all disagree with it.
    logic [DEB:0] m_hn, m_hi;
    logic m_dn, m_di, m_dpn, m_dpi, m_tn, m_ti, m_an, m_ai, m_blank;
    int   m_phase, m_left;   // phase 0 idle, 1 waiting for frame, 2 blanking
    logic m_busy;
    logic [3:0] m_out, d_out;
    assign m_busy = (m_phase != 0);
    assign m_out  = {m_an, m_ai, m_blank, m_busy};
    assign d_out  = {NEG_DIS, IMBA_MODE_ON, BLANK, MODE_BUSY};

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_hn <= '0; m_hi <= '0;
            m_dn <= 1'b0; m_di <= 1'b0; m_dpn <= 1'b0; m_dpi <= 1'b0;
            m_tn <= 1'b0; m_ti <= 1'b0; m_an <= 1'b0; m_ai <= 1'b0;
            m_blank <= 1'b0; m_phase <= 0; m_left <= 0;
        end else begin
            m_hn <= {m_hn[DEB-1:0], BTN_NEG};
            m_hi <= {m_hi[DEB-1:0], BTN_IMBA};
            if (m_hn[DEB:1] == {DEB{~m_dn}}) m_dn <= ~m_dn;
            if (m_hi[DEB:1] == {DEB{~m_di}}) m_di <= ~m_di;
            m_dpn <= m_dn;
            m_dpi <= m_di;
            if (m_dn && !m_dpn) m_tn <= ~m_tn;
            if (m_di && !m_dpi) m_ti <= ~m_ti;
            if (m_phase == 0) begin
                if ({m_tn, m_ti} != {m_an, m_ai}) m_phase <= 1;
            end else if (m_phase == 1) begin
                if ({m_tn, m_ti} == {m_an, m_ai}) begin
                    m_phase <= 0;
                end else if (FRAME_START) begin
                    m_an <= m_tn;
                    m_ai <= m_ti;
                    if (BLANK_EN) begin
                        m_blank <= 1'b1; m_left <= BF; m_phase <= 2;
                    end else begin
                        m_phase <= 0;
                    end
                end
            end else if (FRAME_START) begin
                if (m_left == 1) begin
                    m_blank <= 1'b0; m_phase <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        total++;
        if (d_out !== 4'b0000) begin
            bad++; $display("FAIL reset_values got=%b want=0000", d_out);
        end
        RESET_N = 1'b1;
        for (int c = 0; c < FP + 50; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL reset_idle t=%0t got=%b want=%b", $time, d_out, m_out);
            end
        end
        total++;
        if (d_out !== 4'b0000) begin
            bad++; $display("FAIL reset_no_spurious got=%b want=0000", d_out);
        end
    endtask

    task automatic test_single_press();
        int fs = -1, start = -1, lat = -1, blank_cnt = 0, off;
        off = $urandom_range(300, 50);
        for (int c = 0; c < 5 * FP; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL single_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (start >= 0 && lat < 0 && MODE_BUSY === 1'b1) lat = c - start;
            if (BLANK === 1'b1) blank_cnt++;
            if (fs < 0 && FRAME_START) fs = c;
            if (fs >= 0 && c == fs + off) begin BTN_NEG = 1'b1; start = c; end
            if (start >= 0 && c == start + 10) BTN_NEG = 1'b0;
        end
        total++;
        if (lat != DEB + 4) begin
            bad++; $display("FAIL single_busy_latency got=%0d want=%0d", lat, DEB + 4);
        end
        total++;
        if (NEG_DIS !== 1'b1) begin
            bad++; $display("FAIL single_neg_final got=%b want=1", NEG_DIS);
        end
        total++;
        if (blank_cnt != (BLANK_EN ? BF * FP : 0)) begin
            bad++; $display("FAIL single_blank_len got=%0d want=%0d", blank_cnt, BLANK_EN ? BF * FP : 0);
        end
        total++;
        if (MODE_BUSY !== 1'b0) begin
            bad++; $display("FAIL single_busy_end got=%b want=0", MODE_BUSY);
        end
    endtask

    task automatic test_bounce_cancel();
        bit q[$];
        bit q2[$];
        int qi = 0, ci = 0;
        bit armed = 1'b0, bounce_busy = 1'b0, cancel_busy = 1'b0;
        bit saw_imba = 1'b0, saw_blank = 1'b0;
        for (int p = 0; p < 5; p++) begin
            repeat (3) q.push_back(1'b1);
            repeat ($urandom_range(10, 4)) q.push_back(1'b0);
        end
        repeat (6) q2.push_back(1'b1);
        repeat (10) q2.push_back(1'b0);
        repeat (6) q2.push_back(1'b1);
        for (int c = 0; c < 2 * FP + 200; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL bounce_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (!armed && MODE_BUSY === 1'b1) bounce_busy = 1'b1;
            if (armed && MODE_BUSY === 1'b1) cancel_busy = 1'b1;
            if (IMBA_MODE_ON !== 1'b0) saw_imba = 1'b1;
            if (BLANK !== 1'b0) saw_blank = 1'b1;
            if (qi < q.size()) begin
                BTN_IMBA = q[qi]; qi++;
            end else if (!armed && FRAME_START) begin
                armed = 1'b1;
            end else if (armed && ci < q2.size()) begin
                BTN_IMBA = q2[ci]; ci++;
            end else begin
                BTN_IMBA = 1'b0;
            end
        end
        total++;
        if (bounce_busy) begin
            bad++; $display("FAIL bounce_no_press got=busy want=idle");
        end
        total++;
        if (!cancel_busy) begin
            bad++; $display("FAIL cancel_went_busy got=0 want=1");
        end
        total++;
        if (saw_imba) begin
            bad++; $display("FAIL cancel_imba got=1 want=0");
        end
        total++;
        if (saw_blank) begin
            bad++; $display("FAIL cancel_blank got=1 want=0");
        end
    endtask

    task automatic test_simultaneous();
        int fs = -1, start = -1, blank_cnt = 0, rises = 0, neg_fall = -1, imba_rise = -1, off;
        logic pb = 1'b0, pn = 1'b1, pi = 1'b0;
        off = $urandom_range(400, 20);
        for (int c = 0; c < 5 * FP; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL simul_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (BLANK === 1'b1) blank_cnt++;
            if (BLANK === 1'b1 && pb === 1'b0) rises++;
            if (pn === 1'b1 && NEG_DIS === 1'b0) neg_fall = c;
            if (pi === 1'b0 && IMBA_MODE_ON === 1'b1) imba_rise = c;
            pb = BLANK; pn = NEG_DIS; pi = IMBA_MODE_ON;
            if (fs < 0 && FRAME_START) fs = c;
            if (fs >= 0 && c == fs + off) begin BTN_NEG = 1'b1; BTN_IMBA = 1'b1; start = c; end
            if (start >= 0 && c == start + 8) begin BTN_NEG = 1'b0; BTN_IMBA = 1'b0; end
        end
        total++;
        if (NEG_DIS !== 1'b0 || IMBA_MODE_ON !== 1'b1) begin
            bad++; $display("FAIL simul_final got=%b%b want=01", NEG_DIS, IMBA_MODE_ON);
        end
        total++;
        if (neg_fall < 0 || neg_fall != imba_rise) begin
            bad++; $display("FAIL simul_same_frame got=%0d/%0d want=equal", neg_fall, imba_rise);
        end
        total++;
        if (blank_cnt != (BLANK_EN ? BF * FP : 0) || rises != (BLANK_EN ? 1 : 0)) begin
            bad++; $display("FAIL simul_blank got=%0d/%0d want=%0d/%0d", blank_cnt, rises,
                            BLANK_EN ? BF * FP : 0, BLANK_EN ? 1 : 0);
        end
    endtask

    task automatic test_press_during_blank();
        int fs = -1, p1 = -1, p2 = -1, rise = -1, fall = -1, blank_cnt = 0, rises = 0;
        logic pb = 1'b0, pn = 1'b0;
        for (int c = 0; c < 7 * FP; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL dblank_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (BLANK === 1'b1) blank_cnt++;
            if (BLANK === 1'b1 && pb === 1'b0) rises++;
            if (pn === 1'b0 && NEG_DIS === 1'b1 && rise < 0) rise = c;
            if (pn === 1'b1 && NEG_DIS === 1'b0 && fall < 0) fall = c;
            pb = BLANK; pn = NEG_DIS;
            if (fs < 0 && FRAME_START) fs = c;
            if (fs >= 0 && c == fs + 100) begin BTN_NEG = 1'b1; p1 = c; end
            if (p1 >= 0 && c == p1 + 8) BTN_NEG = 1'b0;
            if (rise >= 0 && c == rise + 300) begin BTN_NEG = 1'b1; p2 = c; end
            if (p2 >= 0 && c == p2 + 8) BTN_NEG = 1'b0;
        end
        total++;
        if (rise < 0 || fall - rise != (BLANK_EN ? (BF + 1) * FP : FP)) begin
            bad++; $display("FAIL dblank_revert_time got=%0d want=%0d", fall - rise,
                            BLANK_EN ? (BF + 1) * FP : FP);
        end
        total++;
        if (NEG_DIS !== 1'b0) begin
            bad++; $display("FAIL dblank_neg_final got=%b want=0", NEG_DIS);
        end
        total++;
        if (blank_cnt != (BLANK_EN ? 2 * BF * FP : 0) || rises != (BLANK_EN ? 2 : 0)) begin
            bad++; $display("FAIL dblank_blanks got=%0d/%0d want=%0d/%0d", blank_cnt, rises,
                            BLANK_EN ? 2 * BF * FP : 0, BLANK_EN ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int fs = -1, pressed = -1, fell = -1, c = 0, rises = 0;
        logic pn = 1'b0;
        while (c < 3 * FP && !(fell >= 0 && c >= fell + 50)) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL rstmid_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (fs < 0 && FRAME_START) fs = c;
            if (fs >= 0 && c == fs + 100) begin BTN_IMBA = 1'b1; pressed = c; end
            if (pressed >= 0 && c == pressed + 8) BTN_IMBA = 1'b0;
            if (pressed >= 0 && fell < 0 && IMBA_MODE_ON === 1'b0) fell = c;
            c++;
        end
        total++;
        if (fell < 0) begin
            bad++; $display("FAIL rstmid_apply_timeout got=none want=imba_off");
        end
        BTN_NEG = 1'b1;
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if (d_out !== 4'b0000) begin
            bad++; $display("FAIL rstmid_async got=%b want=0000", d_out);
        end
        repeat (4) @(negedge CLK);
        RESET_N = 1'b1;
        for (int k = 0; k < 3 * FP; k++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL rstmid_after t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (pn === 1'b0 && NEG_DIS === 1'b1) rises++;
            pn = NEG_DIS;
            if (k == 30) BTN_NEG = 1'b0;
        end
        total++;
        if (NEG_DIS !== 1'b1 || IMBA_MODE_ON !== 1'b0 || rises != 1) begin
            bad++; $display("FAIL rstmid_held_btn got=%b%b/%0d want=10/1", NEG_DIS, IMBA_MODE_ON, rises);
        end
    endtask

    task automatic test_random();
        int rem_n = 0, rem_i = 0;
        for (int c = 0; c < 10 * FP; c++) begin
            @(negedge CLK);
            total++;
            if (d_out !== m_out) begin
                bad++; $display("FAIL random_lockstep t=%0t got=%b want=%b", $time, d_out, m_out);
            end
            if (c > 9 * FP) begin
                BTN_NEG = 1'b0; BTN_IMBA = 1'b0;
            end else begin
                if (rem_n == 0) begin
                    BTN_NEG = 1'($urandom_range(1, 0)); rem_n = $urandom_range(40, 1);
                end else begin
                    rem_n--;
                end
                if (rem_i == 0) begin
                    BTN_IMBA = 1'($urandom_range(1, 0)); rem_i = $urandom_range(400, 1);
                end else begin
                    rem_i--;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce_cancel();
        test_simultaneous();
        test_press_during_blank();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
